// File: rtl/ula_nibble_seq.sv
// Runs a W-bit operation on one shared 4-bit 74181-style slice, one nibble per clock, LSB nibble first.
// Optional macro ULA_SEQ_OVF_EN adds rsp_ovf, the two's-complement overflow for add/subtract codes.
module ula_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic [3:0]           req_s,
  input  logic                 req_m,
  input  logic                 req_c_in,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_f,
  output logic                 rsp_c_out,
  output logic                 rsp_a_eq_b,
  output logic                 busy,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_c_in,
  input  logic [3:0]           alu_f,
  input  logic                 alu_c_out,
  input  logic                 alu_a_eq_b
`ifdef ULA_SEQ_OVF_EN
  ,
  output logic                 rsp_ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    f_q;
  logic [3:0]      s_q;
  logic            m_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            eq;
  logic            run;

  assign run        = (state == RUN);
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign rsp_f      = f_q;
  assign rsp_c_out  = carry;
  assign rsp_a_eq_b = eq;

  // Operands shift down one nibble per RUN cycle, so the slice always sees bits [3:0].
  assign alu_a    = run ? a_q[3:0] : 4'd0;
  assign alu_b    = run ? b_q[3:0] : 4'd0;
  assign alu_s    = run ? s_q : 4'd0;
  assign alu_m    = run ? m_q : 1'b0;
  assign alu_c_in = run ? carry : 1'b0;

`ifdef ULA_SEQ_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf;
  logic ovf_next;

  assign rsp_ovf = ovf;

  always_comb begin
    ovf_next = 1'b0;
    if (!m_q && s_q == 4'b1001)
      ovf_next = (a_msb == b_msb) && (alu_f[3] != a_msb);
    else if (!m_q && s_q == 4'b0110)
      ovf_next = (a_msb != b_msb) && (alu_f[3] != a_msb);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      a_msb <= req_a[W-1];
      b_msb <= req_b[W-1];
      ovf   <= 1'b0;
    end else if (run && idx == LAST) begin
      ovf   <= ovf_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      f_q   <= '0;
      s_q   <= '0;
      m_q   <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      eq    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            s_q   <= req_s;
            m_q   <= req_m;
            carry <= req_c_in;
            eq    <= 1'b1;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Result fills from the top; after NIBBLES cycles nibble 0 sits at the bottom.
          f_q   <= {alu_f, f_q[W-1:4]};
          a_q   <= {4'd0, a_q[W-1:4]};
          b_q   <= {4'd0, b_q[W-1:4]};
          carry <= alu_c_out;
          eq    <= eq & alu_a_eq_b;
          if (idx == LAST)
            state <= DONE;
          else
            idx <= idx + 1'b1;
        end
        DONE: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Bench for ula_nibble_seq: behavioural 74181 slice, wide reference model, vector table,
// randomized operations and hand-written backpressure / reset sequences.
module tb_ula_nibble_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   req_s;
  logic         req_m;
  logic         req_c_in;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_f;
  logic         rsp_c_out;
  logic         rsp_a_eq_b;
  logic         busy;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_c_in;
  logic [3:0]   alu_f;
  logic         alu_c_out;
  logic         alu_a_eq_b;
`ifdef ULA_SEQ_OVF_EN
  logic         rsp_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ula_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_c_in(req_c_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_c_out(rsp_c_out), .rsp_a_eq_b(rsp_a_eq_b), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
    .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b)
`ifdef ULA_SEQ_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  // 74181-style slice, active-high data, true carry in/out.
  logic [3:0] sx;
  logic [3:0] sy;
  logic [4:0] ssum;
  always_comb begin
    sx   = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    sy   = (alu_a & alu_b & {4{alu_s[3]}}) | (alu_a & ~alu_b & {4{alu_s[2]}});
    ssum = {1'b0, sx} + {1'b0, sy} + {4'd0, alu_c_in};
    if (alu_m) begin
      alu_f     = ~(sx ^ sy);
      alu_c_out = 1'b0;
    end else begin
      alu_f     = ssum[3:0];
      alu_c_out = ssum[4];
    end
    alu_a_eq_b = (alu_a == alu_b);
  end

  typedef struct packed {
    logic [W-1:0] f;
    logic         c;
    logic         eq;
    logic         ovf;
  } res_t;

  // Whole-word reference from the function table.
  function automatic res_t ref_op(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] s, logic m, logic cin);
    res_t         r;
    logic [W-1:0] ones;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [W:0]   sum;
    r    = '0;
    ones = '1;
    p    = '0;
    q    = '0;
    r.eq = (a == b);
    if (m) begin
      case (s)
        4'h0: r.f = ~a;
        4'h1: r.f = ~(a | b);
        4'h2: r.f = ~a & b;
        4'h3: r.f = '0;
        4'h4: r.f = ~(a & b);
        4'h5: r.f = ~b;
        4'h6: r.f = a ^ b;
        4'h7: r.f = a & ~b;
        4'h8: r.f = ~a | b;
        4'h9: r.f = ~(a ^ b);
        4'hA: r.f = b;
        4'hB: r.f = a & b;
        4'hC: r.f = ones;
        4'hD: r.f = a | ~b;
        4'hE: r.f = a | b;
        default: r.f = a;
      endcase
    end else begin
      case (s)
        4'h0: begin p = a;      q = '0;     end
        4'h1: begin p = a | b;  q = '0;     end
        4'h2: begin p = a | ~b; q = '0;     end
        4'h3: begin p = ones;   q = '0;     end
        4'h4: begin p = a;      q = a & ~b; end
        4'h5: begin p = a | b;  q = a & ~b; end
        4'h6: begin p = a;      q = ~b;     end
        4'h7: begin p = a & ~b; q = ones;   end
        4'h8: begin p = a;      q = a & b;  end
        4'h9: begin p = a;      q = b;      end
        4'hA: begin p = a | ~b; q = a & b;  end
        4'hB: begin p = ones;   q = a & b;  end
        4'hC: begin p = a;      q = a;      end
        4'hD: begin p = a | b;  q = a;      end
        4'hE: begin p = a | ~b; q = a;      end
        default: begin p = ones; q = a;     end
      endcase
      sum = {1'b0, p} + {1'b0, q} + (W+1)'(cin);
      r.f = sum[W-1:0];
      r.c = sum[W];
      if (s == 4'h9) r.ovf = (a[W-1] == b[W-1]) && (r.f[W-1] != a[W-1]);
      if (s == 4'h6) r.ovf = (a[W-1] != b[W-1]) && (r.f[W-1] != a[W-1]);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                        input logic m, input logic cin, output res_t got, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(guard < 50), 32'd1);
    req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = cin;
    req_valid = 1'b1;
    @(negedge clk);
    // Scramble inputs after acceptance: the latched request must not follow them.
    req_valid = 1'b0;
    req_a = W'($urandom); req_b = W'($urandom); req_s = 4'($urandom);
    req_m = 1'($urandom); req_c_in = 1'($urandom);
    wait_rsp(lat);
    got.f  = rsp_f;
    got.c  = rsp_c_out;
    got.eq = rsp_a_eq_b;
`ifdef ULA_SEQ_OVF_EN
    got.ovf = rsp_ovf;
`else
    got.ovf = 1'b0;
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t got, input res_t exp, input int lat);
    check({tag, ".f"},   32'(got.f),  32'(exp.f));
    check({tag, ".c"},   32'(got.c),  32'(exp.c));
    check({tag, ".eq"},  32'(got.eq), 32'(exp.eq));
    check({tag, ".lat"}, 32'(lat),    32'(N + 1));
`ifdef ULA_SEQ_OVF_EN
    check({tag, ".ovf"}, 32'(got.ovf), 32'(exp.ovf));
`endif
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         cin;
    res_t         exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    res_t got;
    res_t exp;
    int   lat;
    int   seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rs;
    logic         rm;
    logic         rc;

    vecs[0] = '{16'h1234, 16'h0FFF, 4'h9, 1'b0, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{16'h0005, 16'h0007, 4'h6, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{16'h0007, 16'h0005, 4'h6, 1'b0, 1'b1, '{16'h0002, 1'b1, 1'b0, 1'b0}};
    vecs[3] = '{16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b0, '{16'h0FF0, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{16'hABCD, 16'hABCD, 4'h6, 1'b1, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0}};
    vecs[5] = '{16'h7FFF, 16'h0001, 4'h9, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b0, 1'b1}};
    vecs[6] = '{16'h8000, 16'h0001, 4'h6, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b0, 1'b1}};
    vecs[7] = '{16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0}};
    vecs[8] = '{16'h0001, 16'h0001, 4'h9, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b1, 1'b0}};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_c_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.rsp_f", 32'(rsp_f), 32'd0);
    check("rst.rsp_c_eq", 32'({rsp_c_out, rsp_a_eq_b}), 32'd0);
    check("rst.alu_out", 32'({alu_a, alu_b, alu_s, alu_m, alu_c_in}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].cin, got, lat);
      compare($sformatf("vec%0d", i), got, vecs[i].exp, lat);
    end

    // Backpressure with a competing request held on the inputs.
    @(negedge clk);
    req_a = 16'h1111; req_b = 16'h2222; req_s = 4'h9; req_m = 1'b0; req_c_in = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_a = 16'h0100; req_b = 16'h0020;
    wait_rsp(lat);
    check("bp.lat", 32'(lat), 32'(N + 1));
    check("bp.f_first", 32'(rsp_f), 32'h3333);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp.hold_f%0d", k), 32'(rsp_f), 32'h3333);
      check($sformatf("bp.hold_rdy%0d", k), 32'({req_ready, rsp_valid}), 32'b01);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp.idle_after_hs", 32'({req_ready, busy}), 32'b10);
    @(negedge clk);
    check("bp.accept_next", 32'({req_ready, busy}), 32'b01);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("bp.second_f", 32'(rsp_f), 32'h0120);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while RUN is on nibble 2.
    @(negedge clk);
    req_a = 16'h1234; req_b = 16'h1111; req_s = 4'h9; req_m = 1'b0; req_c_in = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid.alu_a_idx2", 32'(alu_a), 32'h2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid.state", 32'({req_ready, rsp_valid, busy}), 32'b100);
    check("rst_mid.rsp", 32'({rsp_f, rsp_c_out, rsp_a_eq_b}), 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst_mid.no_rsp", 32'(seen), 32'd0);
    run_op(16'h0001, 16'h0001, 4'h9, 1'b0, 1'b0, got, lat);
    compare("rst_mid.after", got, ref_op(16'h0001, 16'h0001, 4'h9, 1'b0, 1'b0), lat);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      rs = (i % 3 == 0) ? 4'h9 : ((i % 3 == 1) ? 4'h6 : 4'($urandom));
      rm = (i % 4 == 3) ? 1'b1 : 1'b0;
      rc = 1'($urandom);
      exp = ref_op(ra, rb, rs, rm, rc);
      run_op(ra, rb, rs, rm, rc, got, lat);
      compare($sformatf("rnd%0d", i), got, exp, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
